// File: rtl/life_pkg.sv
// Shared types and rule constants for the life grid engine.
// Imported by the row evaluator and the engine top.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        COMMIT
    } state_t;

    localparam logic [3:0] RULE_BIRTH      = 4'd3;
    localparam logic [3:0] RULE_SURVIVE_LO = 4'd2;
    localparam logic [3:0] RULE_SURVIVE_HI = 4'd3;
    localparam int         GEN_COUNT_W     = 16;

    function automatic logic cell_next(input logic alive, input logic [3:0] n);
        if (alive)
            return (n >= RULE_SURVIVE_LO) && (n <= RULE_SURVIVE_HI);
        return n == RULE_BIRTH;
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation evaluator for one grid row.
// Edge rows/columns read as dead unless wrap is enabled.
module life_row_next
    import life_pkg::*;
#(
    parameter int COLS = 8
) (
    input  logic [COLS-1:0] i_above,
    input  logic [COLS-1:0] i_cur,
    input  logic [COLS-1:0] i_below,
    input  logic            i_wrap,
    input  logic            i_top,
    input  logic            i_bot,
    output logic [COLS-1:0] o_next
);

    logic [COLS-1:0] w_up;
    logic [COLS-1:0] w_dn;

    assign w_up = (i_top && !i_wrap) ? '0 : i_above;
    assign w_dn = (i_bot && !i_wrap) ? '0 : i_below;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int L = (c == 0) ? COLS - 1 : c - 1;
        localparam int R = (c == COLS - 1) ? 0 : c + 1;

        logic       w_lok;
        logic       w_rok;
        logic [3:0] w_n;

        // neighbours across the left/right border only count when wrapping
        assign w_lok = (c != 0) || i_wrap;
        assign w_rok = (c != COLS - 1) || i_wrap;

        assign w_n = 4'(w_up[L] & w_lok) + 4'(w_up[c]) + 4'(w_up[R] & w_rok)
                   + 4'(i_cur[L] & w_lok) + 4'(i_cur[R] & w_rok)
                   + 4'(w_dn[L] & w_lok) + 4'(w_dn[c]) + 4'(w_dn[R] & w_rok);

        assign o_next[c] = cell_next(i_cur[c], w_n);
    end

endmodule

// File: rtl/life_grid_engine.sv
// Game of Life engine: row-serial compute into a shadow buffer,
// atomic commit, row loading and multiplexed matrix drive.
module life_grid_engine
    import life_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int WRAP       = 1,
    parameter int GEN_PERIOD = 1000000,
    parameter int SCAN_DIV   = 1000,
    parameter logic [ROWS*COLS-1:0] INIT_GRID =
        ((ROWS*COLS)'(2))
        | ((ROWS*COLS)'(4) << COLS)
        | ((ROWS*COLS)'(7) << (2 * COLS))
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      step,
    input  logic                      load_valid,
    input  logic [$clog2(ROWS)-1:0]   load_row,
    input  logic [COLS-1:0]           load_data,
    output logic                      load_ready,
    output logic                      busy,
    output logic [GEN_COUNT_W-1:0]    gen_count,
    output logic                      stable,
    output logic                      extinct,
    output logic [ROWS-1:0]           rows_out,
    output logic [COLS-1:0]           columns_out
);

    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(GEN_PERIOD + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(GEN_PERIOD - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ROWS*COLS-1:0]   r_grid;
    logic [ROWS*COLS-1:0]   r_shadow;
    logic [RW-1:0]          r_row;
    logic [RW-1:0]          r_scan;
    logic [PW-1:0]          r_period;
    logic [SW-1:0]          r_scan_cnt;
    logic [GEN_COUNT_W-1:0] r_gen;
    logic                   r_stable;

    logic [RW-1:0]   w_up;
    logic [RW-1:0]   w_dn;
    logic [COLS-1:0] w_next_row;
    logic            w_idle;
    logic            w_period_hit;
    logic            w_step_req;
    logic            w_load;
    logic            w_trig;

    assign w_idle       = r_state == IDLE;
    assign w_period_hit = run && (r_period == PER_LAST);
    assign w_step_req   = w_idle && step && !run;
    assign w_load       = w_idle && load_valid;
    // a load in the same cycle as a trigger wins; the trigger is dropped
    assign w_trig       = w_idle && (w_step_req || w_period_hit) && !w_load;

    assign w_up = (r_row == '0) ? ROW_LAST : r_row - 1'b1;
    assign w_dn = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;

    life_row_next #(
        .COLS(COLS)
    ) u_row (
        .i_above(r_grid[w_up*COLS +: COLS]),
        .i_cur  (r_grid[r_row*COLS +: COLS]),
        .i_below(r_grid[w_dn*COLS +: COLS]),
        .i_wrap (WRAP != 0),
        .i_top  (r_row == '0),
        .i_bot  (r_row == ROW_LAST),
        .o_next (w_next_row)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_trig) w_state_next = COMPUTE;
            COMPUTE: if (r_row == ROW_LAST) w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grid   <= INIT_GRID;
            r_shadow <= '0;
            r_row    <= '0;
            r_period <= '0;
            r_gen    <= '0;
            r_stable <= 1'b0;
        end else begin
            if (w_period_hit || w_step_req)
                r_period <= '0;
            else if (run)
                r_period <= r_period + 1'b1;

            case (r_state)
                IDLE: begin
                    r_row <= '0;
                    if (w_load && (int'(load_row) < ROWS)) begin
                        r_grid[load_row*COLS +: COLS] <= load_data;
                        r_stable <= 1'b0;
                    end
                end
                COMPUTE: begin
                    r_shadow[r_row*COLS +: COLS] <= w_next_row;
                    r_row <= r_row + 1'b1;
                end
                COMMIT: begin
                    r_grid   <= r_shadow;
                    r_gen    <= r_gen + 1'b1;
                    r_stable <= r_shadow == r_grid;
                end
                default: r_row <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan     <= '0;
            r_scan_cnt <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_scan     <= (r_scan == ROW_LAST) ? '0 : r_scan + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign load_ready  = w_idle;
    assign busy        = (r_state == COMPUTE) || (r_state == COMMIT);
    assign gen_count   = r_gen;
    assign stable      = r_stable;
    assign extinct     = r_grid == '0;
    assign rows_out    = {{(ROWS-1){1'b0}}, 1'b1} << r_scan;
    assign columns_out = r_grid[r_scan*COLS +: COLS];

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: a toroidal and a dead-edge
// instance share stimulus and are read back through the scan outputs.
module tb_life_grid_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int GP   = 16;
    localparam int SD   = 4;
    localparam logic [63:0] INIT = 64'h0000_0000_0007_0402;

    logic       clk = 1'b0;
    logic       rst, run, step, load_valid;
    logic [2:0] load_row;
    logic [7:0] load_data;

    logic        a_ready, a_busy, a_stable, a_ext;
    logic [15:0] a_gen;
    logic [7:0]  a_rows, a_cols;
    logic        b_ready, b_busy, b_stable, b_ext;
    logic [15:0] b_gen;
    logic [7:0]  b_rows, b_cols;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    life_grid_engine #(
        .ROWS(ROWS), .COLS(COLS), .WRAP(1), .GEN_PERIOD(GP), .SCAN_DIV(SD)
    ) u_a (
        .clk(clk), .rst(rst), .run(run), .step(step),
        .load_valid(load_valid), .load_row(load_row), .load_data(load_data),
        .load_ready(a_ready), .busy(a_busy), .gen_count(a_gen),
        .stable(a_stable), .extinct(a_ext),
        .rows_out(a_rows), .columns_out(a_cols)
    );

    life_grid_engine #(
        .ROWS(ROWS), .COLS(COLS), .WRAP(0), .GEN_PERIOD(GP), .SCAN_DIV(SD)
    ) u_b (
        .clk(clk), .rst(rst), .run(run), .step(step),
        .load_valid(load_valid), .load_row(load_row), .load_data(load_data),
        .load_ready(b_ready), .busy(b_busy), .gen_count(b_gen),
        .stable(b_stable), .extinct(b_ext),
        .rows_out(b_rows), .columns_out(b_cols)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run = 1'b0;
        step = 1'b0;
        load_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic read_grid(output logic [63:0] ga, output logic [63:0] gb);
        ga = '0;
        gb = '0;
        repeat (ROWS * SD) begin
            @(negedge clk);
            for (int r = 0; r < ROWS; r++) begin
                if (a_rows[r]) ga[r*COLS +: COLS] = a_cols;
                if (b_rows[r]) gb[r*COLS +: COLS] = b_cols;
            end
        end
    endtask

    task automatic load_grid(input logic [63:0] g);
        for (int r = 0; r < ROWS; r++) begin
            load_valid = 1'b1;
            load_row = 3'(r);
            load_data = g[r*COLS +: COLS];
            @(negedge clk);
        end
        load_valid = 1'b0;
    endtask

    task automatic do_step(input string tag);
        int n;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        n = 0;
        while ((a_busy || b_busy) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(a_busy | b_busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] init_v;
        logic [63:0] ga, gb;
        logic [7:0]  er;
        int          n;
        logic        rdy_bad;

        init_v = INIT;
        load_row = '0;
        load_data = '0;

        // reset state and display scan
        do_reset();
        chk("rst_gen", a_gen, 0);
        chk("rst_stable", a_stable, 0);
        chk("rst_extinct", a_ext, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_ready, 1);
        for (int j = 0; j <= ROWS * SD; j++) begin
            if (j > 0) @(negedge clk);
            er = 8'h01 << ((j / SD) % ROWS);
            chk("scan_rows", a_rows, er);
            chk("scan_cols", a_cols, init_v[((j / SD) % ROWS)*COLS +: COLS]);
        end

        // latency, handshake, load ignored while busy
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        n = 0;
        rdy_bad = 1'b0;
        while (a_busy && n < 20) begin
            if (n == 2) begin
                load_valid = 1'b1;
                load_row = 3'd0;
                load_data = 8'hFF;
            end
            if (n == 4) load_valid = 1'b0;
            if (a_ready) rdy_bad = 1'b1;
            n++;
            @(negedge clk);
        end
        load_valid = 1'b0;
        chk("busy_len", 64'(n), 64'd9);
        chk("ready_low", rdy_bad, 0);
        chk("ready_back", a_ready, 1);
        chk("lat_gen", a_gen, 1);
        read_grid(ga, gb);
        chk("gen1_a", ga, 64'h0000_0000_0206_0500);
        chk("gen1_b", gb, 64'h0000_0000_0206_0500);

        // reset during compute row 4
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_gen", a_gen, 0);
        chk("mid_busy", a_busy, 0);
        chk("mid_rows", a_rows, 8'h01);
        chk("mid_cols", a_cols, 8'h02);
        rst = 1'b1;
        read_grid(ga, gb);
        chk("mid_grid", ga, INIT);

        // glider in free-run on the torus
        run = 1'b1;
        n = 0;
        while (!(a_gen == 16'd4 && !a_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        run = 1'b0;
        chk("glider4_gen", a_gen, 4);
        read_grid(ga, gb);
        chk("glider4_a", ga, 64'h0000_0000_0E08_0400);
        chk("glider4_b", gb, 64'h0000_0000_0E08_0400);
        run = 1'b1;
        n = 0;
        while (!(a_gen == 16'd32 && !a_busy) && n < 700) begin
            @(negedge clk);
            n++;
        end
        run = 1'b0;
        chk("glider32_gen", a_gen, 32);
        read_grid(ga, gb);
        chk("glider32_a", ga, INIT);
        chk("glider32_st", a_stable, 0);

        // blinker
        do_reset();
        load_grid(64'h0000_0000_1C00_0000);
        chk("blk_ld_stable", a_stable, 0);
        do_step("blk_s1_done");
        read_grid(ga, gb);
        chk("blk1_a", ga, 64'h0000_0008_0808_0000);
        chk("blk1_b", gb, 64'h0000_0008_0808_0000);
        do_step("blk_s2_done");
        read_grid(ga, gb);
        chk("blk2_a", ga, 64'h0000_0000_1C00_0000);
        chk("blk2_stable", a_stable, 0);
        chk("blk2_gen", a_gen, 2);

        // still life then extinction
        load_grid(64'h0000_0000_0000_0303);
        do_step("blk_sl_done");
        chk("still_stable", a_stable, 1);
        chk("still_ext", a_ext, 0);
        chk("still_b", b_stable, 1);
        load_grid(64'h0000_0000_0000_0001);
        chk("ld_clr_stable", a_stable, 0);
        chk("ld_ext", a_ext, 0);
        do_step("ext_done");
        chk("ext_a", a_ext, 1);
        chk("ext_b", b_ext, 1);
        chk("ext_stable", a_stable, 0);
        read_grid(ga, gb);
        chk("ext_grid", ga, 64'h0);

        // boundary: wrap vs dead edges on rows and columns
        load_grid(64'h0000_0000_8300_0007);
        do_step("edge_done");
        read_grid(ga, gb);
        chk("edge_wrap", ga, 64'h0200_0001_0101_0202);
        chk("edge_dead", gb, 64'h0000_0000_0000_0202);

        // load and step in the same cycle: load wins
        step = 1'b1;
        load_valid = 1'b1;
        load_row = 3'd6;
        load_data = 8'h40;
        @(negedge clk);
        step = 1'b0;
        load_valid = 1'b0;
        chk("lt_busy0", a_busy, 0);
        @(negedge clk);
        chk("lt_busy1", a_busy, 0);
        chk("lt_gen", a_gen, 5);
        read_grid(ga, gb);
        chk("lt_a", ga, 64'h0240_0001_0101_0202);
        chk("lt_b", gb, 64'h0040_0000_0000_0202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
